// File: rtl/narrow_pkg.sv
// narrow_pkg: shared definitions for the 32-to-16 bit narrowing unit.
//   - default widths for the input word, output halfword and overflow counter
//   - saturation constants for signed positive, signed negative, unsigned max
//   - range_ovf(): range check of a 32-bit word against the 16-bit target
//   - payload structs carried by the two pipeline stages
package narrow_pkg;

  localparam int DW_IN_DEF  = 32;
  localparam int DW_OUT_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  localparam logic [15:0] SAT_SPOS = 16'h7FFF;
  localparam logic [15:0] SAT_SNEG = 16'h8000;
  localparam logic [15:0] SAT_UMAX = 16'hFFFF;

  // Stage-1 payload: low half, source sign and mode bits, plus the range verdict.
  typedef struct packed {
    logic        ovf;
    logic        sext;
    logic        sat;
    logic        sign;
    logic [15:0] data;
  } s1_t;

  // Stage-2 payload: final halfword and its overflow flag.
  typedef struct packed {
    logic        ovf;
    logic [15:0] data;
  } s2_t;

  // Signed: bits [31:15] must all equal the sign to fit in 16 bits.
  // Unsigned: bits [31:16] must all be zero.
  function automatic logic range_ovf(input logic [31:0] data, input logic sext);
    logic [16:0] w_hi_s;
    logic [15:0] w_hi_u;
    logic        w_ovf;
    w_hi_s = data[31:15];
    w_hi_u = data[31:16];
    if (sext) begin
      w_ovf = !((&w_hi_s) || (~|w_hi_s));
    end else begin
      w_ovf = |w_hi_u;
    end
    return w_ovf;
  endfunction

endpackage

// File: rtl/narrow_sat_if.sv
// narrow_sat_if: upstream and downstream valid/ready channels of narrow_sat.
//   in_valid/in_ready/in_data/in_sext/in_sat : word to narrow plus its mode
//   out_valid/out_ready/out_data/out_ovf     : narrowed halfword plus overflow flag
// master = producer of input words and consumer of results; slave = narrow_sat.
interface narrow_sat_if
  import narrow_pkg::*;
#(
  parameter int DW_IN  = DW_IN_DEF,
  parameter int DW_OUT = DW_OUT_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DW_IN-1:0]  in_data;
  logic              in_sext;
  logic              in_sat;
  logic              out_valid;
  logic              out_ready;
  logic [DW_OUT-1:0] out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, in_sext, in_sat, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sext, in_sat, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/narrow_stage.sv
// narrow_stage: one valid/ready pipeline register with a W-bit payload.
//   i_up_valid/o_up_ready/i_up_data : upstream side
//   o_dn_valid/i_dn_ready/o_dn_data : downstream side (registered)
// Accepts a new word whenever empty or when the held word leaves in the
// same cycle, so a chain of these runs at one word per cycle.
module narrow_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_up_valid,
  output logic         o_up_ready,
  input  logic [W-1:0] i_up_data,
  output logic         o_dn_valid,
  input  logic         i_dn_ready,
  output logic [W-1:0] o_dn_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_up_ready = !r_valid || i_dn_ready;
  assign w_load     = i_up_valid && o_up_ready;
  assign o_dn_valid = r_valid;
  assign o_dn_data  = r_data;

  // Holding register: load on accept, empty when the held word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_up_data;
    end else if (i_dn_ready) begin
      r_valid <= 1'b0;
      r_data  <= r_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

endmodule

// File: rtl/narrow_sat.sv
// narrow_sat: narrows a 32-bit word to 16 bits, signed or unsigned, with
// saturation or truncation, through a 2-stage valid/ready pipeline.
//   clk, rst_n  : clock and asynchronous active-low reset
//   bus (slave) : input word channel and result channel
//   clr_ovf     : synchronous clear of the overflow statistics
//   ovf_sticky  : set by any overflowed result transfer
//   ovf_count   : saturating count of overflowed result transfers
module narrow_sat
  import narrow_pkg::*;
#(
  parameter int DW_IN  = DW_IN_DEF,
  parameter int DW_OUT = DW_OUT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  narrow_sat_if.slave      bus,
  input  logic             clr_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  s1_t              w_s1_in;
  s1_t              w_s1_out;
  s2_t              w_s2_in;
  s2_t              w_s2_out;
  logic             w_s1_valid;
  logic             w_s2_ready;
  logic             w_ovf_xfer;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_ovf_count;
  logic [DW_OUT-1:0] w_lo;

  assign w_lo = bus.in_data[DW_OUT-1:0];

  // Stage-1 payload: the range check is done before the register.
  always_comb begin
    w_s1_in      = '0;
    w_s1_in.ovf  = range_ovf(bus.in_data, bus.in_sext);
    w_s1_in.sext = bus.in_sext;
    w_s1_in.sat  = bus.in_sat;
    w_s1_in.sign = bus.in_data[DW_IN-1];
    w_s1_in.data = w_lo;
  end

  narrow_stage #(.W($bits(s1_t))) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_up_valid (bus.in_valid),
    .o_up_ready (bus.in_ready),
    .i_up_data  (w_s1_in),
    .o_dn_valid (w_s1_valid),
    .i_dn_ready (w_s2_ready),
    .o_dn_data  (w_s1_out)
  );

  // Result select: only an overflowed word in saturate mode is clamped.
  always_comb begin
    w_s2_in     = '0;
    w_s2_in.ovf = w_s1_out.ovf;
    if (!w_s1_out.ovf || !w_s1_out.sat) begin
      w_s2_in.data = w_s1_out.data;
    end else if (w_s1_out.sext) begin
      w_s2_in.data = w_s1_out.sign ? SAT_SNEG : SAT_SPOS;
    end else begin
      w_s2_in.data = SAT_UMAX;
    end
  end

  narrow_stage #(.W($bits(s2_t))) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_up_valid (w_s1_valid),
    .o_up_ready (w_s2_ready),
    .i_up_data  (w_s2_in),
    .o_dn_valid (bus.out_valid),
    .i_dn_ready (bus.out_ready),
    .o_dn_data  (w_s2_out)
  );

  assign bus.out_data = w_s2_out.data;
  assign bus.out_ovf  = w_s2_out.ovf;

  assign w_ovf_xfer = bus.out_valid && bus.out_ready && bus.out_ovf;

  // Overflow statistics: a clear takes effect first, so a coincident
  // overflow transfer still leaves sticky=1, count=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (clr_ovf) begin
      r_ovf_sticky <= w_ovf_xfer;
      r_ovf_count  <= w_ovf_xfer ? CNT_ONE : '0;
    end else if (w_ovf_xfer) begin
      r_ovf_sticky <= 1'b1;
      r_ovf_count  <= (r_ovf_count == CNT_MAX) ? r_ovf_count : r_ovf_count + CNT_ONE;
    end else begin
      r_ovf_sticky <= r_ovf_sticky;
      r_ovf_count  <= r_ovf_count;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_narrow_sat.sv
// tb_narrow_sat: directed vectors for narrow_sat with a queue-based scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_narrow_sat;
  import narrow_pkg::*;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ovf_sticky;
  logic [7:0] ovf_count;

  narrow_sat_if #(.DW_IN(32), .DW_OUT(16)) bus ();

  narrow_sat #(.DW_IN(32), .DW_OUT(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   base_acc;
  int   base_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Offer one word; the expected result is queued when the accept is seen.
  task automatic send(input logic [31:0] d, input logic sx, input logic st,
                      input logic [15:0] ed, input logic eo);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    e.data = ed;
    e.ovf  = eo;
    bus.in_data  = d;
    bus.in_sext  = sx;
    bus.in_sat   = st;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  // Wait until every queued result has left and the output is idle.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Scoreboard monitor: every output transfer must match the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected none", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_e.data));
        check("out_ovf",  32'(bus.out_ovf),  32'(mon_e.ovf));
        n_pop++;
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_sext   = 1'b0;
    bus.in_sat    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    check("rst_sticky",    32'(ovf_sticky),    32'd0);
    check("rst_count",     32'(ovf_count),     32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Signed saturate
    send(32'h00012345, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    send(32'hFFFE0000, 1'b1, 1'b1, 16'h8000, 1'b1);
    drain();
    check("t1_count",  32'(ovf_count),  32'd2);
    check("t1_sticky", 32'(ovf_sticky), 32'd1);

    // Unsigned truncate vs saturate
    @(posedge clk); #1;
    send(32'h0001ABCD, 1'b0, 1'b0, 16'hABCD, 1'b1);
    send(32'h0001ABCD, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    send(32'h0000FFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    drain();
    check("t2_count", 32'(ovf_count), 32'd4);

    // Signed boundaries
    @(posedge clk); #1;
    send(32'h00007FFF, 1'b1, 1'b1, 16'h7FFF, 1'b0);
    send(32'hFFFF8000, 1'b1, 1'b1, 16'h8000, 1'b0);
    send(32'h00008000, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    drain();
    check("t3_count_once", 32'(ovf_count), 32'd5);
    @(posedge clk); #1;
    send(32'hFFFF7FFF, 1'b1, 1'b0, 16'h7FFF, 1'b1);
    drain();
    check("t3_count_neg", 32'(ovf_count), 32'd6);

    // Backpressure: 4 words with the consumer stalled
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    base_acc = n_acc;
    base_pop = n_pop;
    fork
      begin
        send(32'h00000011, 1'b0, 1'b0, 16'h0011, 1'b0);
        send(32'h00000022, 1'b0, 1'b0, 16'h0022, 1'b0);
        send(32'h00000033, 1'b0, 1'b0, 16'h0033, 1'b0);
        send(32'h00000044, 1'b0, 1'b0, 16'h0044, 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_accepted",  32'(n_acc - base_acc), 32'd2);
        check("bp_in_ready",  32'(bus.in_ready),     32'd0);
        check("bp_out_valid", 32'(bus.out_valid),    32'd1);
        check("bp_hold_data", 32'(bus.out_data),     32'h0011);
        @(negedge clk);
        check("bp_hold_data2", 32'(bus.out_data),    32'h0011);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_popped", 32'(n_pop - base_pop), 32'd4);
    check("bp_count",  32'(ovf_count),        32'd6);

    // Clear alone
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("clr_sticky", 32'(ovf_sticky), 32'd0);
    check("clr_count",  32'(ovf_count),  32'd0);

    // Counter saturation
    for (int k = 0; k < 260; k++) begin
      send(32'h00010000, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    end
    drain();
    check("sat_count",  32'(ovf_count),  32'h000000FF);
    check("sat_sticky", 32'(ovf_sticky), 32'd1);

    // Clear coincident with an overflow transfer
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h00010000, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    begin : wait_valid
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1'b1;
      end
      check("coinc_valid_seen", 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    clr_ovf       = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("coinc_count",  32'(ovf_count),  32'd1);
    check("coinc_sticky", 32'(ovf_sticky), 32'd1);

    // Reset mid-operation with 2 words in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h00012345, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    send(32'h00012345, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_out_data",  32'(bus.out_data),  32'd0);
    check("mrst_sticky",    32'(ovf_sticky),    32'd0);
    check("mrst_count",     32'(ovf_count),     32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mrst_no_stale", 32'(bus.out_valid), 32'd0);

    // Latency after reset: 2 cycles from accept to out_valid
    @(posedge clk); #1;
    send(32'hFFFF7FFF, 1'b1, 1'b1, 16'h8000, 1'b1);
    @(negedge clk);
    check("lat_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(bus.out_valid), 32'd1);
    drain();
    check("lat_count",  32'(ovf_count),  32'd1);
    check("lat_sticky", 32'(ovf_sticky), 32'd1);

    // Clear alone after reset
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("clr2_sticky", 32'(ovf_sticky), 32'd0);
    check("clr2_count",  32'(ovf_count),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/narrow_sat.md
Name: narrow_sat

Overview:
- Inverse of the datapath widening unit: takes a 32-bit value and reduces it to 16 bits.
- Supports signed or unsigned interpretation, with either saturation or plain truncation.
- Flags and counts range overflows.
- Sits between the ALU result bus and the halfword store / immediate-check path; valid/ready on both sides; 2-stage pipeline.

Parameters:
- DW_IN, 32, input data width
- DW_OUT, 16, output data width
- CNT_W, 8, overflow event counter width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept input this cycle
- in_data  input  DW_IN  value to narrow
- in_sext  input  1  1 = signed interpretation, 0 = unsigned
- in_sat  input  1  1 = saturate on overflow, 0 = truncate
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  DW_OUT  narrowed result
- out_ovf  output  1  this result's source was out of range
- ovf_sticky  output  1  set by any overflow, held until cleared
- ovf_count  output  CNT_W  number of overflowed results accepted, saturating
- clr_ovf  input  1  synchronous clear of ovf_sticky and ovf_count

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage-valid flags 0; out_valid 0; out_data 0; out_ovf 0.
  - ovf_sticky 0; ovf_count 0.
  - in_ready is 1 one cycle after release.
  - Reset mid-transfer discards both stages with no output.
- Handshake:
  - A transfer occurs when valid && ready on a port.
  - Once out_valid rises, out_data and out_ovf stay stable until out_ready.
  - No combinational path from in_valid to out_valid.
- Stage 1 (S1), on input accept, registers:
  - in_data[15:0]
  - the sign bit in_data[31]
  - in_sext, in_sat
  - ovf1: when in_sext=1, ovf1 = bits [31:15] not all equal; when in_sext=0, ovf1 = bits [31:16] not all zero.
- Stage 2 (S2) registers the result:
  - ovf1=0: data = low 16 bits.
  - ovf1=1, sat=0: data = low 16 bits.
  - ovf1=1, sat=1, sext=1: 16'h7FFF if sign=0, else 16'h8000.
  - ovf1=1, sat=1, sext=0: 16'hFFFF.
  - out_ovf = ovf1 in all cases.
- Pipeline advance:
  - S2 loads when S1 is valid and (S2 empty or out_ready).
  - S1 loads when in_valid and (S1 empty or S1 moving to S2).
  - in_ready = !s1_valid || s1_advance.
  - Full throughput is 1 word/cycle; latency is 2 cycles from input accept to out_valid.
  - With out_ready held low, the block accepts exactly 2 words, then in_ready=0.
- Overflow statistics are updated on output transfer (out_valid && out_ready && out_ovf):
  - ovf_sticky <= 1.
  - ovf_count increments and saturates at all-ones (no wrap).
  - clr_ovf in the same cycle as an overflow transfer: the clear applies first, then the event counts, giving ovf_sticky=1 and ovf_count=1.
  - clr_ovf alone: sticky 0, count 0.
- Boundary values:
  - Signed: 32'h00007FFF and 32'hFFFF8000 are in range; 32'h00008000 and 32'hFFFF7FFF overflow.
  - Unsigned: 32'h0000FFFF is in range; 32'h00010000 overflows.

Decomposition:
- Shared package narrow_pkg holds:
  - DW_IN/DW_OUT defaults
  - constants SAT_SPOS=16'h7FFF, SAT_SNEG=16'h8000, SAT_UMAX=16'hFFFF
  - a function range_ovf(data, sext)
- One sub-module, narrow_stage: a generic valid/ready pipeline register with payload width parameter, instantiated twice.
- Saturation logic and counters stay in the top module.

Test Plan:
- Signed saturate, out_ready=1. Input 32'h00012345 sext=1 sat=1, then 32'hFFFE0000 sext=1 sat=1 → after 2 cycles out_data 16'h7FFF ovf=1, then 16'h8000 ovf=1; ovf_count=2, ovf_sticky=1.
- Unsigned truncate vs saturate. 32'h0001ABCD sext=0 sat=0 → 16'hABCD ovf=1; same word with sat=1 → 16'hFFFF ovf=1; 32'h0000FFFF sat=1 → 16'hFFFF ovf=0.
- Signed boundaries, sat=1. 32'h00007FFF → 16'h7FFF ovf=0; 32'hFFFF8000 → 16'h8000 ovf=0; 32'h00008000 → 16'h7FFF ovf=1; ovf_count increments only once.
- Backpressure. Stream 4 words with out_ready=0 → in_ready drops after the 2nd accept and out_data holds the 1st result. Then raise out_ready → all 4 results emerge in order, one per cycle, with none lost or duplicated.
- Counter and clear. Drive 260 overflowing words with CNT_W=8 → ovf_count saturates at 8'hFF. Assert clr_ovf coincident with an overflow transfer → ovf_count=1, ovf_sticky=1. clr_ovf alone → both 0.
- Reset mid-operation. With 2 words in flight, pull rst_n low asynchronously (mid-cycle) → out_valid, out_data, ovf_sticky and ovf_count go to 0 immediately. After release, no stale output appears and the next input produces a correct result 2 cycles later.
